// File: rtl/display_scan_controller.sv
// Display scan controller: multiplexes a 4-digit mm:ss time value onto a
// common-anode display, one digit per CLK_DIV-cycle slot. The digit value is
// latched once per frame so a digit never changes while it is being scanned.
module display_scan_controller #(
  parameter int CLK_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        lz_blank_en,
  input  logic [15:0] time_in,
  output logic [15:0] frame_digits,
  output logic [3:0]  selector,
  output logic [3:0]  anode_n,
  output logic        blank,
  output logic        frame_done
);

  // The counter only has to reach CLK_DIV-1, so clog2 of the divisor is enough.
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]       r_state;
  logic [3:0]       r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_frame;
  logic             r_done;
  logic             r_lz;

  logic             w_slotEnd;
  logic             w_blank;

  assign w_slotEnd = (r_cnt == CNT_LAST);

  // Scan state machine: slot divider, one-hot digit rotation and frame latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sel   <= 4'b0000;
      r_cnt   <= '0;
      r_frame <= 16'h0000;
      r_done  <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
      if (enable) begin
        r_state <= ST_SCAN;
        r_sel   <= 4'b0001;
        r_frame <= time_in;
      end
    end else if (!enable) begin
      r_state <= ST_IDLE;
      r_sel   <= 4'b0000;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else if (w_slotEnd) begin
      r_cnt  <= '0;
      r_sel  <= {r_sel[2:0], r_sel[3]};
      r_done <= r_sel[3];
      if (r_sel[3]) begin
        r_frame <= time_in;
      end
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_done <= 1'b0;
    end
  end

  // Registered copy of the leading-zero blanking request, so outputs never
  // depend combinationally on the input pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lz <= 1'b0;
    end else begin
      r_lz <= lz_blank_en;
    end
  end

  // Blank while idle, and blank a zero tens-of-minutes digit when requested.
  always_comb begin
    w_blank = 1'b1;
    if (r_state == ST_SCAN) begin
      w_blank = r_sel[3] && r_lz && (r_frame[15:12] == 4'h0);
    end
  end

  assign frame_digits = r_frame;
  assign selector     = r_sel;
  assign blank        = w_blank;
  assign anode_n      = w_blank ? 4'b1111 : ~r_sel;
  assign frame_done   = r_done;

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller with a 4-cycle slot.
// Expected output vectors are queued when stimulus is applied and compared
// one per cycle, sampled 1 time unit after each rising edge.
module tb_display_scan_controller;

  localparam int DIV = 4;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        lzBlankEn;
  logic [15:0] timeIn;
  logic [15:0] frameDigits;
  logic [3:0]  selector;
  logic [3:0]  anodeN;
  logic        blank;
  logic        frameDone;

  int checks = 0;
  int errors = 0;

  // Packed expectation: {selector, anode_n, blank, frame_done, frame_digits}
  logic [25:0] expQ[$];

  display_scan_controller #(.CLK_DIV(DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .lz_blank_en (lzBlankEn),
    .time_in     (timeIn),
    .frame_digits(frameDigits),
    .selector    (selector),
    .anode_n     (anodeN),
    .blank       (blank),
    .frame_done  (frameDone)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector for cycle k after SCAN entry (k=0 is the entry cycle).
  function automatic logic [25:0] expScan(input int k, input logic [15:0] f,
                                          input logic blk, input logic done);
    logic [3:0] sel;
    sel = 4'(1 << ((k / DIV) % 4));
    return {sel, (blk ? 4'hF : ~sel), blk, done, f};
  endfunction

  function automatic logic [25:0] expIdle(input logic [15:0] f);
    return {4'h0, 4'hF, 1'b1, 1'b0, f};
  endfunction

  // Reset, then release with enable high; the next rising edge enters SCAN.
  task automatic start_scan(input logic [15:0] t, input logic lz);
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; lzBlankEn = lz; timeIn = t;
    @(negedge clk);
    reset = 1'b0; enable = 1'b1;
  endtask

  task automatic test_reset();
    logic [25:0] obs, exp;
    expQ.push_back(expIdle(16'h0000));
    expQ.push_back(expIdle(16'h0000));
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      obs = {selector, anodeN, blank, frameDone, frameDigits};
      exp = expQ.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL reset k=%0d got %h expected %h", k, obs, exp);
      end
      @(negedge clk);
      reset = 1'b0; enable = 1'b0; timeIn = 16'hBEEF;
    end
  endtask

  task automatic test_scan_rotation();
    logic [25:0] obs, exp;
    start_scan(16'h1234, 1'b0);
    for (int k = 0; k < 21; k++) expQ.push_back(expScan(k, 16'h1234, 1'b0, k == 16));
    for (int k = 0; k < 21; k++) begin
      @(posedge clk); #1;
      obs = {selector, anodeN, blank, frameDone, frameDigits};
      exp = expQ.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL scan_rotation k=%0d got %h expected %h", k, obs, exp);
      end
    end
  endtask

  task automatic test_no_tearing();
    logic [25:0] obs, exp;
    start_scan(16'h1234, 1'b0);
    for (int k = 0; k < 20; k++)
      expQ.push_back(expScan(k, (k < 16) ? 16'h1234 : 16'h5678, 1'b0, k == 16));
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      obs = {selector, anodeN, blank, frameDone, frameDigits};
      exp = expQ.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL no_tearing k=%0d got %h expected %h", k, obs, exp);
      end
      if (k == 5) begin
        @(negedge clk);
        timeIn = 16'h5678;
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [25:0] obs, exp;
    start_scan(16'h0959, 1'b1);
    for (int k = 0; k < 32; k++)
      expQ.push_back(expScan(k, (k < 16) ? 16'h0959 : 16'h1959,
                             (k == 12) || (k == 13), k == 16));
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      obs = {selector, anodeN, blank, frameDone, frameDigits};
      exp = expQ.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL lz_blank k=%0d got %h expected %h", k, obs, exp);
      end
      if (k == 3) begin
        @(negedge clk);
        timeIn = 16'h1959;
      end else if (k == 13) begin
        @(negedge clk);
        lzBlankEn = 1'b0;
      end else if (k == 15) begin
        @(negedge clk);
        lzBlankEn = 1'b1;
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [25:0] obs, exp;
    start_scan(16'h1234, 1'b0);
    for (int k = 0; k < 18; k++) begin
      if (k <= 10)      expQ.push_back(expScan(k, 16'h1234, 1'b0, 1'b0));
      else if (k <= 12) expQ.push_back(expIdle(16'h1234));
      else              expQ.push_back(expScan(k - 13, 16'h4321, 1'b0, 1'b0));
    end
    for (int k = 0; k < 18; k++) begin
      @(posedge clk); #1;
      obs = {selector, anodeN, blank, frameDone, frameDigits};
      exp = expQ.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL enable_drop k=%0d got %h expected %h", k, obs, exp);
      end
      if (k == 10) begin
        @(negedge clk);
        enable = 1'b0; timeIn = 16'h4321;
      end else if (k == 12) begin
        @(negedge clk);
        enable = 1'b1;
      end
    end
  endtask

  task automatic test_reset_mid_scan(input int rstAt);
    logic [25:0] obs, exp;
    start_scan(16'hF0A9, 1'b0);
    for (int k = 0; k <= rstAt + 3; k++) begin
      if (k <= rstAt)          expQ.push_back(expScan(k, 16'hF0A9, 1'b0, 1'b0));
      else if (k == rstAt + 1) expQ.push_back(expIdle(16'h0000));
      else                     expQ.push_back(expScan(k - rstAt - 2, 16'hF0A9, 1'b0, 1'b0));
    end
    for (int k = 0; k <= rstAt + 3; k++) begin
      @(posedge clk); #1;
      obs = {selector, anodeN, blank, frameDone, frameDigits};
      exp = expQ.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL reset_mid_scan at=%0d k=%0d got %h expected %h",
                 rstAt, k, obs, exp);
      end
      if (k == rstAt) begin
        @(negedge clk);
        reset = 1'b1;
      end else if (k == rstAt + 1) begin
        @(negedge clk);
        reset = 1'b0;
      end
    end
  endtask

  // Test sequence.
  initial begin
    reset = 1'b1; enable = 1'b0; lzBlankEn = 1'b0; timeIn = 16'h0000;
    test_reset();
    test_scan_rotation();
    test_no_tearing();
    test_lz_blank();
    test_enable_drop();
    test_reset_mid_scan(13);
    test_reset_mid_scan(15);
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_leftover got %0d entries expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
